// File: rtl/adpll_ref_select.sv
// adpll_ref_select: N-input reference front end for the ADPLL.
// Synchronises each candidate reference into fpga_clk_i and qualifies it with a
// loss-of-reference watchdog. A DRAIN/SWAP/ARM sequence switches channels
// without glitches, under manual selection or automatic failover.
// Optional feature: define REF_FREQ_MEAS_EN to add period_o / period_valid_o,
// which report the period of the active channel.
module adpll_ref_select #(
    parameter int unsigned                NUM_REFS      = 4,
    parameter int unsigned                SEL_WIDTH     = 2,
    parameter int unsigned                SYNC_STAGES   = 2,
    parameter int unsigned                TIMEOUT_WIDTH = 12,
    parameter logic [TIMEOUT_WIDTH-1:0]   TIMEOUT       = 12'd4000,
    parameter int unsigned                QUAL_EDGES    = 4
) (
    input  logic                     fpga_clk_i,
    input  logic                     reset_i,
    input  logic [NUM_REFS-1:0]      ref_clk_i,
    input  logic [SEL_WIDTH-1:0]     sel_i,
    input  logic                     auto_i,
    output logic                     ref_clk_o,
    output logic [SEL_WIDTH-1:0]     active_o,
    output logic [NUM_REFS-1:0]      ref_valid_o,
    output logic                     switching_o,
    output logic                     no_ref_o
`ifdef REF_FREQ_MEAS_EN
    ,
    output logic [TIMEOUT_WIDTH-1:0] period_o,
    output logic                     period_valid_o
`endif
);

    localparam int unsigned               EDGE_W     = $clog2(QUAL_EDGES + 1);
    localparam logic [EDGE_W-1:0]         QUAL_MAX   = EDGE_W'(QUAL_EDGES);
    localparam logic [EDGE_W-1:0]         QUAL_M1    = EDGE_W'(QUAL_EDGES - 1);
    localparam logic [TIMEOUT_WIDTH-1:0]  TIMEOUT_M1 = TIMEOUT - 1'b1;

    typedef enum logic [2:0] {StHold, StArm, StRun, StDrain, StSwap} state_e;

    // ---------------------------------------------------------------- sync
    logic [NUM_REFS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_REFS-1:0] s;
    logic [NUM_REFS-1:0] s_d_q;
    logic [NUM_REFS-1:0] rise;

    // Synchroniser chain plus one edge-detect flop per channel.
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
            s_d_q <= '0;
        end else begin
            sync_q[0] <= ref_clk_i;
            for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
            s_d_q <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d_q;

    // ------------------------------------------------------------ watchdog
    logic [TIMEOUT_WIDTH-1:0] wd_cnt_q   [NUM_REFS];
    logic [TIMEOUT_WIDTH-1:0] wd_cnt_d   [NUM_REFS];
    logic [EDGE_W-1:0]        edge_cnt_q [NUM_REFS];
    logic [EDGE_W-1:0]        edge_cnt_d [NUM_REFS];
    logic [NUM_REFS-1:0]      valid_q;
    logic [NUM_REFS-1:0]      valid_d;
    logic [NUM_REFS-1:0]      to_evt;
    logic                     no_ref_q;

    // Per-channel watchdog: a rise clears the counter; a rise that follows a timeout
    // restarts qualification but does not count as an in-time edge.
    always_comb begin
        for (int n = 0; n < int'(NUM_REFS); n++) begin
            wd_cnt_d[n]   = wd_cnt_q[n];
            edge_cnt_d[n] = edge_cnt_q[n];
            valid_d[n]    = valid_q[n];
            to_evt[n]     = ~rise[n] & (wd_cnt_q[n] >= TIMEOUT_M1);
            if (rise[n]) begin
                wd_cnt_d[n] = '0;
                if (wd_cnt_q[n] < TIMEOUT) begin
                    if (edge_cnt_q[n] < QUAL_MAX) edge_cnt_d[n] = edge_cnt_q[n] + 1'b1;
                    if (edge_cnt_q[n] == QUAL_M1) valid_d[n] = 1'b1;
                end
            end else begin
                if (wd_cnt_q[n] < TIMEOUT) wd_cnt_d[n] = wd_cnt_q[n] + 1'b1;
                if (to_evt[n]) begin
                    valid_d[n]    = 1'b0;
                    edge_cnt_d[n] = '0;
                end
            end
        end
    end

    // Watchdog state registers and the registered no-reference flag.
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int n = 0; n < int'(NUM_REFS); n++) begin
                wd_cnt_q[n]   <= '0;
                edge_cnt_q[n] <= '0;
            end
            valid_q  <= '0;
            no_ref_q <= 1'b1;
        end else begin
            for (int n = 0; n < int'(NUM_REFS); n++) begin
                wd_cnt_q[n]   <= wd_cnt_d[n];
                edge_cnt_q[n] <= edge_cnt_d[n];
            end
            valid_q  <= valid_d;
            no_ref_q <= ~|valid_d;
        end
    end

    // ------------------------------------------------------- target select
    logic [SEL_WIDTH-1:0] sel_eff;
    logic [SEL_WIDTH-1:0] low_idx;
    logic [SEL_WIDTH-1:0] target;
    logic [SEL_WIDTH-1:0] active_q;
    logic                 any_valid;

    // Out-of-range selections fall back to channel 0.
    if (NUM_REFS < (1 << SEL_WIDTH)) begin : gen_sel_clip
        localparam logic [SEL_WIDTH-1:0] LAST = SEL_WIDTH'(NUM_REFS - 1);
        assign sel_eff = (sel_i > LAST) ? '0 : sel_i;
    end else begin : gen_sel_full
        assign sel_eff = sel_i;
    end

    assign any_valid = |valid_q;

    // Target priority: manual selection, else preferred, current, lowest valid.
    always_comb begin
        low_idx = '0;
        for (int i = int'(NUM_REFS) - 1; i >= 0; i--) begin
            if (valid_q[i]) low_idx = SEL_WIDTH'(i);
        end
        if (!auto_i)                 target = sel_eff;
        else if (valid_q[sel_eff])   target = sel_eff;
        else if (valid_q[active_q])  target = active_q;
        else if (any_valid)          target = low_idx;
        else                         target = active_q;
    end

    // ----------------------------------------------------------------- FSM
    state_e                   state_q, state_d;
    logic [SEL_WIDTH-1:0]     active_d;
    logic                     ref_out_q, ref_out_d;
    logic [TIMEOUT_WIDTH-1:0] drain_cnt_q, drain_cnt_d;
    logic                     act_lvl;
    logic                     act_ok;

    assign act_lvl = s_d_q[active_q];
    assign act_ok  = valid_q[active_q];

    // Switchover sequencing: let the current high phase finish, swap while low,
    // then wait for a low level on the new channel so the first pulse is whole.
    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        ref_out_d   = 1'b0;
        drain_cnt_d = '0;
        unique case (state_q)
            StRun: begin
                ref_out_d = act_lvl;
                if ((target != active_q) || (auto_i && !act_ok)) state_d = StDrain;
            end
            StDrain: begin
                if (!act_lvl || (drain_cnt_q == TIMEOUT_M1)) begin
                    state_d = StSwap;
                end else begin
                    ref_out_d   = 1'b1;
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            StSwap: begin
                active_d = target;
                state_d  = StArm;
            end
            StArm: begin
                if (auto_i && !any_valid)  state_d = StHold;
                else if (auto_i && !act_ok) state_d = StSwap;
                else if (!act_lvl)         state_d = StRun;
            end
            StHold: begin
                if (!auto_i || any_valid) state_d = StArm;
            end
            default: state_d = StHold;
        endcase
    end

    // FSM and output registers.
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StHold;
            active_q    <= '0;
            ref_out_q   <= 1'b0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            ref_out_q   <= ref_out_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    assign ref_clk_o   = ref_out_q;
    assign active_o    = active_q;
    assign ref_valid_o = valid_q;
    assign switching_o = (state_q != StRun);
    assign no_ref_o    = no_ref_q;

`ifdef REF_FREQ_MEAS_EN
    logic [TIMEOUT_WIDTH-1:0] period_q;
    logic                     period_valid_q;
    logic [1:0]               pedge_q;

    // The watchdog counter already holds cycles-since-last-rise, so the period
    // is that count plus one at the next rise of the active channel.
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            period_q       <= '0;
            period_valid_q <= 1'b0;
            pedge_q        <= '0;
        end else if ((state_q == StSwap) || to_evt[active_q]) begin
            period_valid_q <= 1'b0;
            pedge_q        <= '0;
        end else if (rise[active_q]) begin
            period_q <= wd_cnt_q[active_q] + 1'b1;
            if (pedge_q != 2'd2) pedge_q <= pedge_q + 1'b1;
            if (pedge_q != 2'd0) period_valid_q <= 1'b1;
        end
    end

    assign period_o       = period_q;
    assign period_valid_o = period_valid_q;
`endif

endmodule

// File: tb/tb_adpll_ref_select.sv
// tb_adpll_ref_select: directed bench for adpll_ref_select. References are
// generated as whole-cycle square waves changing on the falling fpga clock edge.
module tb_adpll_ref_select;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] ref_clk;
    logic [1:0] sel;
    logic       auto_en;
    logic       ref_out;
    logic [1:0] active;
    logic [3:0] valid;
    logic       switching;
    logic       no_ref;
`ifdef REF_FREQ_MEAS_EN
    logic [11:0] period;
    logic        period_valid;
`endif

    int hp[4];    // half period in fpga cycles
    int ph[4];
    int mode[4];  // 0 = held low, 1 = running, 2 = stuck high
    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    adpll_ref_select #(
        .NUM_REFS      (4),
        .SEL_WIDTH     (2),
        .SYNC_STAGES   (2),
        .TIMEOUT_WIDTH (12),
        .TIMEOUT       (12'd4000),
        .QUAL_EDGES    (4)
    ) dut (
        .fpga_clk_i     (clk),
        .reset_i        (rst),
        .ref_clk_i      (ref_clk),
        .sel_i          (sel),
        .auto_i         (auto_en),
        .ref_clk_o      (ref_out),
        .active_o       (active),
        .ref_valid_o    (valid),
        .switching_o    (switching),
        .no_ref_o       (no_ref)
`ifdef REF_FREQ_MEAS_EN
        ,
        .period_o       (period),
        .period_valid_o (period_valid)
`endif
    );

    // Reference generators.
    always @(negedge clk) begin
        for (int n = 0; n < 4; n++) begin
            case (mode[n])
                1: begin
                    if (ph[n] >= hp[n] - 1) begin
                        ph[n]      = 0;
                        ref_clk[n] = ~ref_clk[n];
                    end else begin
                        ph[n] = ph[n] + 1;
                    end
                end
                2: ref_clk[n] = 1'b1;
                default: begin
                    ref_clk[n] = 1'b0;
                    ph[n]      = 0;
                end
            endcase
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns on the posedge that first sees the new high level of channel ch.
    task automatic wait_rise(input int ch, input int limit, output bit ok);
        logic prev;
        ok   = 1'b0;
        prev = ref_clk[ch];
        for (int i = 0; i < limit && !ok; i++) begin
            @(posedge clk);
            if (ref_clk[ch] && !prev) ok = 1'b1;
            prev = ref_clk[ch];
        end
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            tick(1);
            if (!switching) ok = 1'b1;
        end
    endtask

    initial begin
        bit   ok;
        bit   all_ok;
        int   lat;
        int   hi;
        int   minw;
        int   lastw;
        bit   started;
        bit   sw_ok;
        bit   got_act;
        logic prev_out;

        ref_clk = '0;
        sel     = 2'd0;
        auto_en = 1'b0;
        hp[0] = 13; hp[1] = 25; hp[2] = 17; hp[3] = 11;
        for (int n = 0; n < 4; n++) mode[n] = 0;

        tick(3);
        check("rst_ref_clk_o", int'(ref_out), 0);
        check("rst_active_o", int'(active), 0);
        check("rst_ref_valid_o", int'(valid), 0);
        check("rst_switching_o", int'(switching), 1);
        check("rst_no_ref_o", int'(no_ref), 1);

        rst = 1'b0;
        mode[0] = 1; mode[1] = 1; mode[2] = 1;

        // Qualification: valid after the fourth in-time edge.
        all_ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_rise(0, 100, ok);
            all_ok &= ok;
        end
        tick(2);
        check("valid_after_3_edges", int'(valid[0]), 0);
        wait_rise(0, 100, ok);
        all_ok &= ok;
        tick(2);
        check("ch0_edges_seen", int'(all_ok), 1);
        check("valid_after_4_edges", int'(valid[0]), 1);
        check("no_ref_clears", int'(no_ref), 0);

        // Latency and pulse width in RUN on channel 0.
        wait_rise(0, 100, ok);
        lat = 1;
        #1;
        while (!ref_out && lat < 20) begin
            tick(1);
            lat++;
        end
        check("latency_cycles", lat, 4);
        check("s1_switching_low", int'(switching), 0);
        check("s1_active_ch0", int'(active), 0);
        hi = 0;
        while (ref_out && hi < 100) begin
            tick(1);
            hi++;
        end
        check("s1_high_width", hi, 13);
`ifdef REF_FREQ_MEAS_EN
        tick(60);
        check("period_ch0", int'(period), 26);
        check("period_valid_ch0", int'(period_valid), 1);
`endif

        // Manual switch 0 -> 1.
        sel      = 2'd1;
        prev_out = ref_out;
        hi       = 0;
        started  = 1'b0;
        minw     = 1000;
        lastw    = 0;
        sw_ok    = 1'b1;
        got_act  = 1'b0;
        for (int c = 0; c < 300; c++) begin
            tick(1);
            if (!got_act && active == 2'd1) begin
                got_act = 1'b1;
`ifdef REF_FREQ_MEAS_EN
                check("period_valid_cleared_on_swap", int'(period_valid), 0);
`endif
            end
            if (!got_act && !switching) sw_ok = 1'b0;
            if (ref_out) begin
                if (!prev_out) begin
                    started = 1'b1;
                    hi      = 0;
                end
                hi++;
            end else if (prev_out && started) begin
                if (hi < minw) minw = hi;
                lastw = hi;
            end
            prev_out = ref_out;
        end
        check("s2_active_ch1", int'(active), 1);
        check("s2_switching_done", int'(switching), 0);
        check("s2_switching_held", int'(sw_ok), 1);
        check("s2_min_high_ge12", int'(minw >= 12), 1);
        check("s2_ch1_high_width", lastw, 25);

        // Auto mode: preferred ch0 is valid, so it is selected again.
        auto_en = 1'b1;
        sel     = 2'd0;
        tick(3);
        wait_idle(400, ok);
        check("s3_idle", int'(ok), 1);
        check("s3_active_ch0", int'(active), 0);

        // Stop ch0 right after a rise and time the loss.
        wait_rise(0, 100, ok);
        mode[0] = 0;
        tick(4001);
        check("valid0_before_timeout", int'(valid[0]), 1);
        tick(1);
        check("valid0_at_timeout", int'(valid[0]), 0);
        tick(1);
        wait_idle(200, ok);
        check("s3_failover_idle", int'(ok), 1);
        check("s3_failover_ch1", int'(active), 1);

        // Restart ch0: preferred channel is taken back once requalified.
        mode[0] = 1;
        ok = 1'b0;
        for (int c = 0; c < 600 && !ok; c++) begin
            tick(1);
            if (active == 2'd0 && !switching) ok = 1'b1;
        end
        check("s3_return_ch0", int'(ok), 1);
        check("s3_valid0_again", int'(valid[0]), 1);

        // Ch0 stuck high mid-pulse, ch1 stopped: drain times out, ch2 takes over.
        wait_rise(0, 100, ok);
        tick(3);
        mode[0] = 2;
        mode[1] = 0;
        ok = 1'b0;
        for (int c = 0; c < 4200 && !ok; c++) begin
            tick(1);
            if (!valid[0]) ok = 1'b1;
        end
        check("s4_stuck_lost", int'(ok), 1);
        check("s4_output_held_high", int'(ref_out), 1);
        lat = 0;
        while (ref_out && lat < 5000) begin
            tick(1);
            lat++;
        end
        check("s4_drain_timeout", lat, 4001);
        wait_idle(100, ok);
        check("s4_active_ch2", int'(active), 2);
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            tick(1);
            if (ref_out) ok = 1'b1;
        end
        hi = 0;
        while (ref_out && hi < 100) begin
            tick(1);
            hi++;
        end
        check("s4_ch2_high_width", hi, 17);

        // All references gone.
        mode[0] = 0;
        mode[2] = 0;
        tick(4100);
        check("s5_no_ref", int'(no_ref), 1);
        check("s5_ref_clk_low", int'(ref_out), 0);
        check("s5_switching_high", int'(switching), 1);
        check("s5_all_invalid", int'(valid), 0);
        mode[3] = 1;
        wait_idle(600, ok);
        check("s5_run_ch3", int'(active), 3);
        check("s5_no_ref_clear", int'(no_ref), 0);
        check("s5_valid_ch3_only", int'(valid), 8);

        // Reset in the middle of a manual switch.
        auto_en = 1'b0;
        sel     = 2'd1;
        tick(2);
        check("s6_switching", int'(switching), 1);
        rst = 1'b1;
        #1;
        check("s6_rst_ref_clk_o", int'(ref_out), 0);
        check("s6_rst_active_o", int'(active), 0);
        check("s6_rst_valid", int'(valid), 0);
        check("s6_rst_switching", int'(switching), 1);
        check("s6_rst_no_ref", int'(no_ref), 1);
        tick(2);
        rst = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
